// File: rtl/pkmc_sdram_refresh_timer.sv
`default_nettype none
// ============================================================================
//  Module   : pkmc_sdram_refresh_timer
//  Purpose  : Power-up delay, init auto-refresh counting and periodic refresh
//             request generation for the PKMC SDRAM controller FSM.
//  Revision : 1.0 - initial release
// ============================================================================
module pkmc_sdram_refresh_timer #(
  parameter int PWRUP_CYCLES   = 5000,
  parameter int INIT_REFRESHES = 8,
  parameter int REF_PERIOD     = 390,
  parameter int PEND_W         = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              irqAck_i,
  output logic              pwrupDone_o,
  output logic              irq_o,
  output logic              initCount_o,
  output logic [PEND_W-1:0] pending_o,
  output logic              overrun_o
);

  localparam int PWR_W  = (PWRUP_CYCLES   > 1) ? $clog2(PWRUP_CYCLES)   : 1;
  localparam int INIT_W = (INIT_REFRESHES > 1) ? $clog2(INIT_REFRESHES) : 1;
  localparam int PER_W  = (REF_PERIOD     > 1) ? $clog2(REF_PERIOD)     : 1;

  localparam logic [PWR_W-1:0]  PWR_LAST  = PWR_W'(PWRUP_CYCLES - 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_REFRESHES - 1);
  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(REF_PERIOD - 1);

  typedef enum logic [1:0] {
    S_PWRUP    = 2'd0,
    S_INIT_REF = 2'd1,
    S_RUN      = 2'd2
  } state_t;

  state_t              r_state;
  logic [PWR_W-1:0]    r_pwr_cnt;
  logic [INIT_W-1:0]   r_init_cnt;
  logic [PER_W-1:0]    r_per_cnt;
  logic [PEND_W-1:0]   r_pending;
  logic                r_pwrup_done;
  logic                r_init_count;
  logic                r_overrun;

  logic                w_tick;
  logic                w_pend_full;

  assign w_tick      = (r_state == S_RUN) && enable_i && (r_per_cnt == PER_LAST);
  assign w_pend_full = &r_pending;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_PWRUP;
      r_pwr_cnt    <= '0;
      r_init_cnt   <= '0;
      r_per_cnt    <= '0;
      r_pending    <= '0;
      r_pwrup_done <= 1'b0;
      r_init_count <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      case (r_state)
        S_PWRUP: begin
          if (r_pwr_cnt == PWR_LAST) begin
            r_state      <= S_INIT_REF;
            r_pwrup_done <= 1'b1;
          end else begin
            r_pwr_cnt <= r_pwr_cnt + 1'b1;
          end
        end

        S_INIT_REF: begin
          if (irqAck_i) begin
            if (r_init_cnt == INIT_LAST) begin
              r_state      <= S_RUN;
              r_init_count <= 1'b1;
              r_per_cnt    <= '0;
            end else begin
              r_init_cnt <= r_init_cnt + 1'b1;
            end
          end
        end

        S_RUN: begin
          if (enable_i) begin
            r_per_cnt <= (r_per_cnt == PER_LAST) ? '0 : r_per_cnt + 1'b1;
          end
          // A tick and an ack in the same cycle cancel; neither overruns.
          if (w_tick && !irqAck_i) begin
            if (w_pend_full) begin
              r_overrun <= 1'b1;
            end else begin
              r_pending <= r_pending + 1'b1;
            end
          end else if (!w_tick && irqAck_i && (r_pending != '0)) begin
            r_pending <= r_pending - 1'b1;
          end
        end

        default: begin
          r_state <= S_PWRUP;
        end
      endcase
    end
  end

  assign pwrupDone_o = r_pwrup_done;
  assign initCount_o = r_init_count;
  assign pending_o   = r_pending;
  assign overrun_o   = r_overrun;
  assign irq_o       = (r_state == S_INIT_REF) || (r_pending != '0);

endmodule
`default_nettype wire

// File: tb/tb_pkmc_sdram_refresh_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pkmc_sdram_refresh_timer
//  Purpose  : Scoreboard bench for pkmc_sdram_refresh_timer (directed vectors).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pkmc_sdram_refresh_timer;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       enable_i = 1'b0;
  logic       irqAck_i = 1'b0;
  logic       pwrupDone_o;
  logic       irq_o;
  logic       initCount_o;
  logic [2:0] pending_o;
  logic       overrun_o;

  pkmc_sdram_refresh_timer #(
    .PWRUP_CYCLES  (20),
    .INIT_REFRESHES(8),
    .REF_PERIOD    (10),
    .PEND_W        (3)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .enable_i   (enable_i),
    .irqAck_i   (irqAck_i),
    .pwrupDone_o(pwrupDone_o),
    .irq_o      (irq_o),
    .initCount_o(initCount_o),
    .pending_o  (pending_o),
    .overrun_o  (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    string      nm;
    logic [6:0] v;   // {pwrupDone, irq, initCount, pending[2:0], overrun}
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic push(input int c, input string nm, input logic pd, input logic irq,
                      input logic ic, input logic [2:0] pend, input logic ov);
    exp_t e;
    e.cyc = c;
    e.nm  = nm;
    e.v   = {pd, irq, ic, pend, ov};
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic ack_pulse();
    irqAck_i = 1'b1;
    tick();
    irqAck_i = 1'b0;
  endtask

  // Monitor: sample mid-cycle and retire every expectation due by now.
  initial begin
    logic [6:0] act;
    forever begin
      @(negedge clk_i);
      act = {pwrupDone_o, irq_o, initCount_o, pending_o, overrun_o};
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        n_chk++;
        if (q[0].cyc < cyc) begin
          n_fail++;
          $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)",
                   q[0].nm, q[0].cyc, cyc);
        end else if (act !== q[0].v) begin
          n_fail++;
          $display("FAIL %s @%0d: got pd=%b irq=%b ic=%b pend=%0d ov=%b, want pd=%b irq=%b ic=%b pend=%0d ov=%b",
                   q[0].nm, cyc, act[6], act[5], act[4], act[3:1], act[0],
                   q[0].v[6], q[0].v[5], q[0].v[4], q[0].v[3:1], q[0].v[0]);
        end
        void'(q.pop_front());
      end
    end
  end

  initial begin
    repeat (5000) @(posedge clk_i);
    $display("FAIL watchdog: bench did not finish within 5000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, r, b2;
    tick();
    push(cyc, "reset", 0, 0, 0, 3'd0, 0);
    tick();
    tick();
    rst_i    = 1'b0;
    enable_i = 1'b1;
    b  = cyc;        // first cycle with reset low
    r  = b + 60;     // first RUN cycle
    b2 = r + 156;    // first cycle after the in-run reset

    push(b + 19,  "pwrup_not_yet",   0, 0, 0, 3'd0, 0);
    push(b + 20,  "pwrup_done",      1, 1, 0, 3'd0, 0);
    push(b + 55,  "init_7th_ack",    1, 1, 0, 3'd0, 0);
    push(r,       "init_complete",   1, 0, 1, 3'd0, 0);
    push(r + 9,   "run_before_tick", 1, 0, 1, 3'd0, 0);
    push(r + 10,  "run_tick1",       1, 1, 1, 3'd1, 0);
    push(r + 12,  "run_tick1_hold",  1, 1, 1, 3'd1, 0);
    push(r + 13,  "run_ack1",        1, 0, 1, 3'd0, 0);
    push(r + 20,  "run_tick2",       1, 1, 1, 3'd1, 0);
    push(r + 23,  "run_ack2",        1, 0, 1, 3'd0, 0);
    push(r + 30,  "frozen_no_tick",  1, 0, 1, 3'd0, 0);
    push(r + 54,  "frozen_pre_tick", 1, 0, 1, 3'd0, 0);
    push(r + 55,  "delayed_tick",    1, 1, 1, 3'd1, 0);
    push(r + 65,  "pend_2",          1, 1, 1, 3'd2, 0);
    push(r + 115, "pend_7",          1, 1, 1, 3'd7, 0);
    push(r + 124, "pend_7_hold",     1, 1, 1, 3'd7, 0);
    push(r + 125, "overrun",         1, 1, 1, 3'd7, 1);
    push(r + 127, "ack_after_ovr",   1, 1, 1, 3'd6, 1);
    push(r + 131, "pend_down_2",     1, 1, 1, 3'd2, 1);
    push(r + 134, "pre_coincident",  1, 1, 1, 3'd2, 1);
    push(r + 135, "tick_and_ack",    1, 1, 1, 3'd2, 1);
    push(r + 155, "pend_4",          1, 1, 1, 3'd4, 1);
    push(r + 156, "run_reset",       0, 0, 0, 3'd0, 0);
    push(b2 + 19, "repwr_not_yet",   0, 0, 0, 3'd0, 0);
    push(b2 + 20, "repwr_done",      1, 1, 0, 3'd0, 0);

    // Power-up: an ack here must be ignored.
    repeat (5) tick();
    ack_pulse();
    repeat (14) tick();
    // Init: eight acks, one every five cycles.
    for (int k = 0; k < 8; k++) begin
      repeat (4) tick();
      ack_pulse();
    end
    // Run: ack three cycles after each request, two periods.
    repeat (12) tick();
    ack_pulse();
    repeat (9) tick();
    ack_pulse();
    // Freeze the period counter for 25 cycles.
    enable_i = 1'b0;
    repeat (25) tick();
    enable_i = 1'b1;
    // No acks until the pending counter saturates and overruns.
    repeat (78) tick();
    ack_pulse();
    // Drain to 2, then ack on the tick cycle.
    irqAck_i = 1'b1;
    repeat (4) tick();
    irqAck_i = 1'b0;
    repeat (3) tick();
    ack_pulse();
    // Reach pending 4, then a single-cycle reset.
    repeat (20) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    repeat (23) tick();

    while (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: expectation for cycle %0d left unchecked", q[0].nm, q[0].cyc);
      void'(q.pop_front());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
